e203_tb_irq_sched: RTL and testbench

Programmable interrupt-injection scheduler for the E203 SoC simulation bench. It drives three interrupt lines (external/PLIC, software/CLINT, timer/CLINT) with randomized or fixed inter-arrival delays. Each line is held until the core signals that its handler has been reached (ack) or a timeout expires. The bench forces the subsys_main irq nets from this block's outputs and gates its end-of-test check on quiescent.

---
 rtl/e203_tb_irq_sched.sv | 153 +++++++++++++++
 tb/tb_e203_tb_irq_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_tb_irq_sched.sv
// e203_tb_irq_sched: interrupt-injection scheduler for the E203 SoC simulation bench.
// Drives one irq line per channel (bit 0 ext, bit 1 sft, bit 2 tmr) after a fixed or
// LFSR-random delay. A line is held until its handler acks it or a timeout expires.
//   clk_i        hfclk domain clock
//   rst_ni       asynchronous active-low reset
//   start_i      pulse: arm the scheduler
//   stop_i       level: disarm; no new injections while high (stop beats start)
//   fixed_mode_i 1 = fixed_dly_i for every channel, 0 = LFSR random delay
//   fixed_dly_i  fixed delay in cycles, 0 behaves as 1
//   ack_i        per-channel handler-reached pulse, only honoured while asserting
//   irq_o        registered interrupt request per channel
//   armed_o      scheduler armed flag
//   quiescent_o  no channel asserting and irq_o == 0
//   inj_cnt_o    saturating count of acknowledged injections
//   tmo_err_o    sticky per-channel timeout flag
module e203_tb_irq_sched #(
    parameter int unsigned CH_NUM  = 3,
    parameter int unsigned DLY_W   = 10,
    parameter int unsigned MIN_DLY = 1,
    parameter int unsigned MAX_DLY = 1000,
    parameter int unsigned TMO_W   = 12,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              fixed_mode_i,
    input  logic [DLY_W-1:0]  fixed_dly_i,
    input  logic [CH_NUM-1:0] ack_i,
    output logic [CH_NUM-1:0] irq_o,
    output logic              armed_o,
    output logic              quiescent_o,
    output logic [31:0]       inj_cnt_o,
    output logic [CH_NUM-1:0] tmo_err_o
);
    typedef enum logic [1:0] {ST_OFF, ST_WAIT, ST_ASSERT} state_e;

    // an all-zero seed would lock the LFSR, so it falls back to the default
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int unsigned RANGE     = MAX_DLY - MIN_DLY;

    logic              armed_q, armed_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [31:0]       inj_cnt_q, inj_cnt_d;
    logic [32:0]       inj_sum;
    logic [CH_NUM-1:0] busy;
    logic [DLY_W-1:0]  fix_dly;

    // Draw from the LFSR rotated left by sh; draws above RANGE fold back onto the
    // low end so every value lands in [MIN_DLY, MAX_DLY].
    function automatic logic [DLY_W-1:0] rand_dly(input logic [15:0] v, input int unsigned sh);
        logic [DLY_W-1:0] r;
        r = DLY_W'(({v, v} << sh) >> 16);
        return (32'(r) > RANGE) ? DLY_W'(32'(r) - RANGE - 32'd1 + MIN_DLY)
                                : DLY_W'(32'(r) + MIN_DLY);
    endfunction

    assign fix_dly = (fixed_dly_i == '0) ? DLY_W'(1) : fixed_dly_i;

    always_comb begin
        armed_d   = stop_i ? 1'b0 : (start_i | armed_q);
        lfsr_d    = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0);
        inj_sum   = {1'b0, inj_cnt_q} + 33'($countones(ack_i & busy));
        inj_cnt_d = inj_sum[32] ? '1 : inj_sum[31:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed_q   <= 1'b0;
            lfsr_q    <= LFSR_INIT;
            inj_cnt_q <= '0;
        end else begin
            armed_q   <= armed_d;
            lfsr_q    <= lfsr_d;
            inj_cnt_q <= inj_cnt_d;
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        state_e           state_q, state_d;
        logic [DLY_W-1:0] dly_q, dly_d, next_dly;
        logic [TMO_W-1:0] tmo_q, tmo_d;
        logic             irq_q, irq_d, err_q, err_d, done;

        // tmo_q counts ASSERT cycles starting at 1, so the line is held 2^TMO_W-1 cycles
        // at most; an ack in the final cycle still wins over the timeout.
        assign done     = (state_q == ST_ASSERT) && (ack_i[c] || tmo_q == '1);
        assign next_dly = fixed_mode_i ? fix_dly : rand_dly(lfsr_q, 32'((5 * c) % 16));

        always_comb begin
            state_d = state_q;
            dly_d   = dly_q;
            tmo_d   = tmo_q;
            irq_d   = irq_q;
            err_d   = err_q | (done & ~ack_i[c]);
            case (state_q)
                ST_OFF: begin
                    if (armed_q) begin
                        state_d = ST_WAIT;
                        dly_d   = next_dly;
                    end
                end
                ST_WAIT: begin
                    if (!armed_q) begin
                        state_d = ST_OFF;
                    end else if (dly_q == DLY_W'(1)) begin
                        state_d = ST_ASSERT;
                        irq_d   = 1'b1;
                        tmo_d   = TMO_W'(1);
                    end else begin
                        dly_d = dly_q - DLY_W'(1);
                    end
                end
                ST_ASSERT: begin
                    if (done) begin
                        state_d = armed_q ? ST_WAIT : ST_OFF;
                        dly_d   = next_dly;
                        irq_d   = 1'b0;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= ST_OFF;
                dly_q   <= '0;
                tmo_q   <= '0;
                irq_q   <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                dly_q   <= dly_d;
                tmo_q   <= tmo_d;
                irq_q   <= irq_d;
                err_q   <= err_d;
            end
        end

        assign busy[c]      = (state_q == ST_ASSERT);
        assign irq_o[c]     = irq_q;
        assign tmo_err_o[c] = err_q;
    end

    assign armed_o     = armed_q;
    assign inj_cnt_o   = inj_cnt_q;
    assign quiescent_o = ~|busy & ~|irq_o;
endmodule

// File: tb/tb_e203_tb_irq_sched.sv
// tb_e203_tb_irq_sched: self-checking bench for e203_tb_irq_sched against a timestamp-based
// reference model (each channel keeps the absolute cycle its line is due to rise).
module tb_e203_tb_irq_sched;
    localparam int CH       = 3;
    localparam int DW       = 10;
    localparam int MIN_D    = 1;
    localparam int MAX_D    = 1000;
    localparam int TW       = 4;
    localparam int HOLD_MAX = (1 << TW) - 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0, stop = 1'b0, fixed_mode = 1'b0;
    logic [DW-1:0] fixed_dly = '0;
    logic [CH-1:0] ack = '0;
    logic [CH-1:0] irq, tmo_err;
    logic          armed, quiescent;
    logic [31:0]   inj_cnt;
    logic [39:0]   dv;
    int            total = 0, bad = 0;

    // model: ph 0 idle, 1 scheduled (line rises at cycle due), 2 line high for hi cycles
    int          ph [CH];
    longint      due [CH];
    int          hi [CH];
    int          last_d [CH];
    logic        m_armed;
    logic [15:0] m_lfsr;
    logic [31:0] m_cnt;
    logic [CH-1:0] m_tmo;
    longint      cyc = 0;

    e203_tb_irq_sched #(
        .CH_NUM(CH), .DLY_W(DW), .MIN_DLY(MIN_D), .MAX_DLY(MAX_D), .TMO_W(TW), .SEED(SEED)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
        .fixed_mode_i(fixed_mode), .fixed_dly_i(fixed_dly), .ack_i(ack),
        .irq_o(irq), .armed_o(armed), .quiescent_o(quiescent),
        .inj_cnt_o(inj_cnt), .tmo_err_o(tmo_err)
    );

    assign dv = {irq, armed, quiescent, inj_cnt, tmo_err};

    always #5 clk = ~clk;

    function automatic int pick_dly(int i, logic [15:0] l);
        int v, s, r;
        if (fixed_mode) return (fixed_dly == 0) ? 1 : int'(fixed_dly);
        v = int'(l);
        s = (5 * i) % 16;
        r = ((v << s) | (v >> (16 - s))) & 32'hFFFF;
        r = r % (1 << DW);
        return (r > MAX_D - MIN_D) ? MIN_D + r - (MAX_D - MIN_D) - 1 : MIN_D + r;
    endfunction

    function automatic logic [39:0] exp_vec();
        logic [CH-1:0] e;
        e = '0;
        for (int i = 0; i < CH; i++) e[i] = (ph[i] == 2);
        return {e, m_armed, e == '0, m_cnt, m_tmo};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            ph[i] = 0; due[i] = 0; hi[i] = 0; last_d[i] = 0;
        end
        m_armed = 1'b0; m_lfsr = SEED; m_cnt = '0; m_tmo = '0;
    endtask

    task automatic resched(input int i, input logic a, input logic [15:0] l);
        if (a) begin
            ph[i] = 1; last_d[i] = pick_dly(i, l); due[i] = cyc + last_d[i];
        end else begin
            ph[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic a;
        logic [15:0] l;
        int n;
        longint s;
        a = m_armed; l = m_lfsr; n = 0;
        cyc++;
        for (int i = 0; i < CH; i++) begin
            if (ph[i] == 0) begin
                if (a) resched(i, a, l);
            end else if (ph[i] == 1) begin
                if (!a) ph[i] = 0;
                else if (cyc == due[i]) begin ph[i] = 2; hi[i] = 1; end
            end else if (ack[i]) begin
                n++; resched(i, a, l);
            end else if (hi[i] == HOLD_MAX) begin
                m_tmo[i] = 1'b1; resched(i, a, l);
            end else begin
                hi[i]++;
            end
        end
        s = longint'(m_cnt) + n;
        m_cnt = (s > longint'(32'hFFFFFFFF)) ? 32'hFFFFFFFF : s[31:0];
        m_armed = stop ? 1'b0 : (start | a);
        m_lfsr = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        model_reset();
        start = 1'b0; stop = 1'b0; ack = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (irq !== 3'b000) $display("FAIL reset_irq: got %b want 000", irq);
        total++; if (armed !== 1'b0) $display("FAIL reset_armed: got %b want 0", armed);
        total++; if (quiescent !== 1'b1) $display("FAIL reset_quiescent: got %b want 1", quiescent);
        total++; if (inj_cnt !== 32'd0) $display("FAIL reset_inj_cnt: got %0d want 0", inj_cnt);
        total++; if (tmo_err !== 3'b000) $display("FAIL reset_tmo_err: got %b want 000", tmo_err);
        bad += (irq !== 3'b000) + (armed !== 1'b0) + (quiescent !== 1'b1) + (inj_cnt !== 32'd0) + (tmo_err !== 3'b000);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_fixed_basic();
        int n;
        fixed_mode = 1'b1; fixed_dly = 10'd5; start = 1'b1;
        step();
        start = 1'b0;
        total++; if (armed !== 1'b1) begin bad++; $display("FAIL fixed_armed: got %b want 1", armed); end
        n = 1;
        for (int k = 0; k < 20 && irq !== 3'b111; k++) begin
            step(); n++;
            total++; if (dv !== exp_vec()) begin bad++; $display("FAIL fixed_vec: got %h want %h", dv, exp_vec()); end
        end
        total++; if (n != 7) begin bad++; $display("FAIL fixed_rise_cycle: got %0d want 7", n); end
        repeat (3) begin
            step();
            total++;
            if (irq !== 3'b111 || quiescent !== 1'b0) begin
                bad++; $display("FAIL fixed_hold: got irq=%b q=%b want irq=111 q=0", irq, quiescent);
            end
        end
    endtask

    task automatic test_ack();
        int n;
        ack = 3'b011;
        step();
        ack = 3'b111;
        total++; if (irq !== 3'b100) begin bad++; $display("FAIL ack_irq: got %b want 100", irq); end
        total++; if (inj_cnt !== 32'd2) begin bad++; $display("FAIL ack_cnt: got %0d want 2", inj_cnt); end
        step();
        ack = '0;
        n = 1;
        total++; if (inj_cnt !== 32'd3) begin bad++; $display("FAIL ack_wait_ignored: got %0d want 3", inj_cnt); end
        for (int k = 0; k < 20 && irq !== 3'b011; k++) begin
            step(); n++;
            total++; if (dv !== exp_vec()) begin bad++; $display("FAIL ack_vec: got %h want %h", dv, exp_vec()); end
        end
        total++; if (n != 5) begin bad++; $display("FAIL ack_rearm: got %0d want 5", n); end
        step();
        total++; if (irq !== 3'b111) begin bad++; $display("FAIL ack_all_high: got %b want 111", irq); end
        ack = 3'b111;
        step();
        ack = '0;
        total++; if (inj_cnt !== 32'd6) begin bad++; $display("FAIL ack_triple: got %0d want 6", inj_cnt); end
    endtask

    task automatic test_fixed_zero();
        int n;
        apply_reset();
        fixed_mode = 1'b1; fixed_dly = '0; start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        for (int k = 0; k < 10 && irq === 3'b000; k++) begin
            step(); n++;
            total++; if (dv !== exp_vec()) begin bad++; $display("FAIL zero_vec: got %h want %h", dv, exp_vec()); end
        end
        total++; if (n != 3 || irq !== 3'b111) begin bad++; $display("FAIL zero_rise: got n=%0d irq=%b want n=3 irq=111", n, irq); end
        ack = 3'b111;
        step();
        ack = '0;
        total++; if (irq !== 3'b000 || inj_cnt !== 32'd3) begin bad++; $display("FAIL zero_ack: got irq=%b cnt=%0d want 000/3", irq, inj_cnt); end
        step();
        total++; if (irq !== 3'b111) begin bad++; $display("FAIL zero_rerise: got %b want 111", irq); end
        ack = 3'b111;
        step();
        ack = '0;
    endtask

    task automatic test_stop();
        apply_reset();
        fixed_mode = 1'b1; fixed_dly = 10'd5; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        total++; if (armed !== 1'b0) begin bad++; $display("FAIL stop_wins: got %b want 0", armed); end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20 && irq !== 3'b111; k++) begin
            step();
            total++; if (dv !== exp_vec()) begin bad++; $display("FAIL stop_vec: got %h want %h", dv, exp_vec()); end
        end
        fixed_dly = 10'd10; ack = 3'b101;
        step();
        ack = '0; stop = 1'b1;
        total++; if (irq !== 3'b010 || inj_cnt !== 32'd2) begin bad++; $display("FAIL stop_pre: got irq=%b cnt=%0d want 010/2", irq, inj_cnt); end
        step();
        total++; if (armed !== 1'b0 || irq !== 3'b010) begin bad++; $display("FAIL stop_hold: got armed=%b irq=%b want 0/010", armed, irq); end
        repeat (2) step();
        ack = 3'b010;
        step();
        ack = '0;
        total++; if (irq !== 3'b000 || inj_cnt !== 32'd3) begin bad++; $display("FAIL stop_ack: got irq=%b cnt=%0d want 000/3", irq, inj_cnt); end
        ack = 3'b111;
        step();
        ack = '0;
        repeat (20) begin
            step();
            total++; if (irq !== 3'b000 || dv !== exp_vec()) begin bad++; $display("FAIL stop_idle: got %h want %h", dv, exp_vec()); end
        end
        total++; if (quiescent !== 1'b1 || inj_cnt !== 32'd3) begin bad++; $display("FAIL stop_end: got q=%b cnt=%0d want 1/3", quiescent, inj_cnt); end
        stop = 1'b0;
    endtask

    task automatic test_timeout();
        apply_reset();
        fixed_mode = 1'b1; fixed_dly = 10'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20 && irq !== 3'b111; k++) step();
        repeat (HOLD_MAX - 1) begin
            step();
            total++; if (irq !== 3'b111) begin bad++; $display("FAIL tmo_hold: got %b want 111", irq); end
        end
        ack = 3'b010;
        step();
        ack = '0;
        total++; if (irq !== 3'b000) begin bad++; $display("FAIL tmo_fall: got %b want 000", irq); end
        total++; if (tmo_err !== 3'b101) begin bad++; $display("FAIL tmo_err: got %b want 101", tmo_err); end
        total++; if (inj_cnt !== 32'd1) begin bad++; $display("FAIL tmo_cnt: got %0d want 1", inj_cnt); end
        repeat (5) begin
            step();
            total++; if (dv !== exp_vec()) begin bad++; $display("FAIL tmo_vec: got %h want %h", dv, exp_vec()); end
        end
    endtask

    task automatic test_random();
        int acks;
        longint d;
        longint last_ack [CH];
        logic [CH-1:0] prev;
        apply_reset();
        fixed_mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        acks = 0; prev = '0;
        for (int i = 0; i < CH; i++) last_ack[i] = -1;
        for (int k = 0; k < 40000 && acks < 60; k++) begin
            total++; if (dv !== exp_vec()) begin bad++; $display("FAIL rand_vec cyc=%0d: got %h want %h", cyc, dv, exp_vec()); end
            for (int i = 0; i < CH; i++) begin
                if (irq[i] && !prev[i] && last_ack[i] >= 0) begin
                    d = cyc - (last_ack[i] + 1);
                    total++;
                    if (d < MIN_D || d > MAX_D || d != last_d[i]) begin
                        bad++; $display("FAIL rand_dly ch%0d: got %0d want %0d", i, d, last_d[i]);
                    end
                end
                if (irq[i]) last_ack[i] = cyc;
            end
            prev = irq; ack = irq; acks += $countones(irq);
            step();
        end
        ack = '0;
        total++; if (acks < 60) begin bad++; $display("FAIL rand_budget: got %0d acks want 60", acks); end
    endtask

    task automatic test_async_reset();
        int n;
        apply_reset();
        fixed_mode = 1'b1; fixed_dly = 10'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 400 && m_cnt < 7; k++) begin
            ack = irq & 3'b001;
            step();
            total++; if (dv !== exp_vec()) begin bad++; $display("FAIL arst_vec: got %h want %h", dv, exp_vec()); end
        end
        ack = '0;
        total++; if (inj_cnt !== 32'd7) begin bad++; $display("FAIL arst_pre_cnt: got %0d want 7", inj_cnt); end
        for (int k = 0; k < 20 && irq === 3'b000; k++) step();
        total++; if (irq === 3'b000) begin bad++; $display("FAIL arst_mid_assert: got %b want nonzero", irq); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (irq !== 3'b000 || inj_cnt !== 32'd0 || armed !== 1'b0 || tmo_err !== 3'b000 || quiescent !== 1'b1) begin
            bad++; $display("FAIL arst_clear: got irq=%b cnt=%0d armed=%b err=%b q=%b want 000/0/0/000/1", irq, inj_cnt, armed, tmo_err, quiescent);
        end
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        total++; if (armed !== 1'b1) begin bad++; $display("FAIL arst_rearm: got %b want 1", armed); end
        for (int k = 0; k < 20 && irq !== 3'b111; k++) begin
            step(); n++;
            total++; if (dv !== exp_vec()) begin bad++; $display("FAIL arst_resume_vec: got %h want %h", dv, exp_vec()); end
        end
        total++; if (n != 4) begin bad++; $display("FAIL arst_resume: got %0d want 4", n); end
    endtask

    initial begin
        test_reset();
        test_fixed_basic();
        test_ack();
        test_fixed_zero();
        test_stop();
        test_timeout();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
